fpu_float_aux_pipe: RTL
=======================

Name: fpu_float_aux_pipe

Overview:
- Parametrised, latency-configurable FP writeback pipeline for the non-arithmetic FP ops: FSGNJ/FSGNJN/FSGNJX, FMIN/FMAX and FMV.W.X.
- Sits beside the add/sub and mul units behind the FP-regfile writeback arbiter.
- Replaces the fixed 3-stage, whole-pipe-stall alignment path with a generic e_p/m_p datapath, a latency_p-deep bubble-collapsing pipe, and full RISC-V NaN semantics for min/max.

Parameters:
- e_p, 8, exponent width
- m_p, 23, mantissa width
- data_width_p, e_p+m_p+1, operand/result width
- reg_addr_width_p, 5, destination register address width
- latency_p, 3, pipeline stages from accept to v_o (legal range 1..8)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- v_i  in  1  input valid
- op_i  in  3  operation: 0 FSGNJ, 1 FSGNJN, 2 FSGNJX, 3 FMIN, 4 FMAX, 5 FMV_W_X, 6-7 reserved (behave as FMV_W_X)
- a_i  in  data_width_p  operand a (integer source for FMV_W_X)
- b_i  in  data_width_p  operand b
- rd_i  in  reg_addr_width_p  destination register
- ready_o  out  1  input can be accepted
- v_o  out  1  result valid
- result_o  out  data_width_p  result
- rd_o  out  reg_addr_width_p  destination of result
- yumi_i  in  1  consumer takes result; legal only when v_o=1
- busy_o  out  1  any stage holds a valid entry

Behaviour:
- Interface: one clock clk_i; reset_i is synchronous and active-high.
- Accept occurs when v_i & ready_o. Result is computed combinationally from a_i/b_i/op_i and captured into stage 1 together with rd_i.
- Stages 1..latency_p each hold valid, result and rd. Stage latency_p drives v_o/result_o/rd_o.
- Advance rule (bubble-collapsing):
  - last stage frees when ~valid | yumi_i.
  - Stage k moves into k+1 when stage k+1 is empty or freeing.
  - ready_o = stage 1 empty or moving.
  - Entries never reorder and never duplicate.
- Latency: accept at cycle t with yumi_i held high gives v_o at t+latency_p. Throughput is 1/cycle.
- Under backpressure the pipe holds latency_p entries. ready_o drops only when all stages are valid and yumi_i=0.
- Simultaneous yumi_i and accept with a full pipe: ready_o=1, and both occur in the same cycle.
- Sign injection: result = {s, a[data_width_p-2:0]}.
  - FSGNJ: s = b.sign
  - FSGNJN: s = ~b.sign
  - FSGNJX: s = a.sign ^ b.sign
  - NaN payloads pass through unchanged.
- NaN: exponent all ones and mantissa != 0. sNaN is a NaN with mantissa MSB = 0. Canonical NaN = {0, all-ones exponent, 1, zeros}.
- FMIN/FMAX:
  - Both NaN: canonical NaN.
  - Exactly one NaN: the other operand.
  - Otherwise sign-magnitude compare, with -0 < +0. Equal operands return a.
- FMV_W_X: result = a_i.
- Reset:
  - All valids clear; v_o=0, busy_o=0.
  - result_o and rd_o are 0.
  - ready_o=0 while reset_i=1 and 1 on the first cycle after.
  - Reset mid-operation silently drops all in-flight entries; nothing emerges afterward.
- yumi_i with v_o=0 is illegal. A simulation assertion fires on it.

Optional Feature:
- Macro: FPU_FLOAT_AUX_PIPE_INVALID_EN
- When defined:
  - Adds output port invalid_o (1 bit).
  - The flag is computed at accept as (op FMIN|FMAX) & (a sNaN | b sNaN) and pipelined alongside result/rd.
  - invalid_o is valid when v_o=1 and is 0 on reset.
- When undefined: the port and its stage registers do not exist. Datapath behaviour is otherwise identical.

Test Plan:
- Sign injection, latency_p=3, yumi_i=1: FSGNJN a=0x3F800000 b=0x3F800000 accepted at t0 -> at t3 v_o=1, result_o=0xBF800000, rd_o=rd_i. FSGNJX a=0xC0000000 b=0x80000000 -> 0x40000000.
- Signed zeros: FMIN a=0x00000000 b=0x80000000 -> 0x80000000. FMAX with the same operands -> 0x00000000.
- NaN rules:
  - FMIN a=0x7FC00000 b=0x40000000 -> 0x40000000.
  - FMAX a=0x7F800001 b=0xFFC00000 -> 0x7FC00000.
  - With the macro defined, invalid_o=1 on the second op and 0 on the first.
- Bubble collapse, latency_p=3, yumi_i=0:
  - Accept at t0 and t2 with a bubble at t1 -> both entries pack to the tail; ready_o stays 1.
  - A third accept fills the pipe; ready_o=0 next cycle.
  - Pulsing yumi_i for one cycle releases exactly one entry in order, and ready_o=1 in that same cycle.
- Back-to-back streaming: 20 consecutive random FMV_W_X ops with yumi_i=1 -> 20 results in order, one per cycle, starting at t0+3. ready_o is never low.
- Reset mid-flight: 2 entries in the pipe, assert reset_i for 1 cycle -> v_o=0 and busy_o=0 the next cycle; no stale result ever appears. A new accept then returns with normal latency.

Source files
------------

// File: rtl/fpu_float_aux_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fpu_float_aux_pipe
// Desc     : Sign-injection / min-max / move writeback pipe with a
//            bubble-collapsing LATENCY_P-deep stage chain. Defining
//            FPU_FLOAT_AUX_PIPE_INVALID_EN adds the pipelined invalid_o flag.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_float_aux_pipe #(
    parameter int E_P              = 8,
    parameter int M_P              = 23,
    parameter int DATA_WIDTH_P     = E_P + M_P + 1,
    parameter int REG_ADDR_WIDTH_P = 5,
    parameter int LATENCY_P        = 3
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        v_i,
    input  logic [2:0]                  op_i,
    input  logic [DATA_WIDTH_P-1:0]     a_i,
    input  logic [DATA_WIDTH_P-1:0]     b_i,
    input  logic [REG_ADDR_WIDTH_P-1:0] rd_i,
    output logic                        ready_o,
    output logic                        v_o,
    output logic [DATA_WIDTH_P-1:0]     result_o,
    output logic [REG_ADDR_WIDTH_P-1:0] rd_o,
    input  logic                        yumi_i,
`ifdef FPU_FLOAT_AUX_PIPE_INVALID_EN
    output logic                        invalid_o,
`endif
    output logic                        busy_o
);

    localparam logic [2:0] c_op_fsgnj    = 3'd0;
    localparam logic [2:0] c_op_fsgnjn   = 3'd1;
    localparam logic [2:0] c_op_fsgnjx   = 3'd2;
    localparam logic [2:0] c_op_fmin     = 3'd3;
    localparam logic [2:0] c_op_fmax     = 3'd4;
    localparam logic [2:0] c_op_fmv_w_x  = 3'd5;

    localparam logic [DATA_WIDTH_P-1:0] c_canon_nan =
        {1'b0, {E_P{1'b1}}, 1'b1, {(M_P-1){1'b0}}};

    // ------------------------------------------------------------------
    // Operand classification
    // ------------------------------------------------------------------
    logic           w_a_sign, w_b_sign;
    logic [E_P-1:0] w_a_exp,  w_b_exp;
    logic [M_P-1:0] w_a_man,  w_b_man;
    logic           w_a_nan,  w_b_nan;
    logic           w_a_lt_b, w_b_lt_a;

    assign w_a_sign = a_i[DATA_WIDTH_P-1];
    assign w_b_sign = b_i[DATA_WIDTH_P-1];
    assign w_a_exp  = a_i[DATA_WIDTH_P-2 -: E_P];
    assign w_b_exp  = b_i[DATA_WIDTH_P-2 -: E_P];
    assign w_a_man  = a_i[M_P-1:0];
    assign w_b_man  = b_i[M_P-1:0];
    assign w_a_nan  = (&w_a_exp) & (|w_a_man);
    assign w_b_nan  = (&w_b_exp) & (|w_b_man);

    // Sign-magnitude ordering; differing signs make -0 order below +0.
    function automatic logic f_lt(input logic [DATA_WIDTH_P-1:0] x,
                                  input logic [DATA_WIDTH_P-1:0] y);
        logic r;
        if (x[DATA_WIDTH_P-1] != y[DATA_WIDTH_P-1])
            r = x[DATA_WIDTH_P-1];
        else if (!x[DATA_WIDTH_P-1])
            r = (x[DATA_WIDTH_P-2:0] < y[DATA_WIDTH_P-2:0]);
        else
            r = (x[DATA_WIDTH_P-2:0] > y[DATA_WIDTH_P-2:0]);
        return r;
    endfunction

    assign w_a_lt_b = f_lt(a_i, b_i);
    assign w_b_lt_a = f_lt(b_i, a_i);

    // ------------------------------------------------------------------
    // Result selection
    // ------------------------------------------------------------------
    logic [DATA_WIDTH_P-1:0] w_result;

    always_comb begin
        w_result = a_i;
        case (op_i)
            c_op_fsgnj:   w_result = {w_b_sign,            a_i[DATA_WIDTH_P-2:0]};
            c_op_fsgnjn:  w_result = {~w_b_sign,           a_i[DATA_WIDTH_P-2:0]};
            c_op_fsgnjx:  w_result = {w_a_sign ^ w_b_sign, a_i[DATA_WIDTH_P-2:0]};
            c_op_fmin, c_op_fmax: begin
                if (w_a_nan && w_b_nan)
                    w_result = c_canon_nan;
                else if (w_a_nan)
                    w_result = b_i;
                else if (w_b_nan)
                    w_result = a_i;
                else if (op_i == c_op_fmin)
                    w_result = w_b_lt_a ? b_i : a_i;
                else
                    w_result = w_a_lt_b ? b_i : a_i;
            end
            c_op_fmv_w_x: w_result = a_i;
            default:      w_result = a_i;
        endcase
    end

`ifdef FPU_FLOAT_AUX_PIPE_INVALID_EN
    logic w_inv;
    assign w_inv = ((op_i == c_op_fmin) || (op_i == c_op_fmax)) &&
                   ((w_a_nan && !w_a_man[M_P-1]) || (w_b_nan && !w_b_man[M_P-1]));
`endif

    // ------------------------------------------------------------------
    // Bubble-collapsing stage chain
    // ------------------------------------------------------------------
    logic [LATENCY_P-1:0]        r_valid;
    logic [DATA_WIDTH_P-1:0]     r_result [LATENCY_P];
    logic [REG_ADDR_WIDTH_P-1:0] r_rd     [LATENCY_P];
    logic [LATENCY_P-1:0]        w_open;
    logic [LATENCY_P-1:0]        w_in_valid;
    logic [DATA_WIDTH_P-1:0]     w_in_result [LATENCY_P];
    logic [REG_ADDR_WIDTH_P-1:0] w_in_rd     [LATENCY_P];
    logic                        w_accept;
`ifdef FPU_FLOAT_AUX_PIPE_INVALID_EN
    logic [LATENCY_P-1:0]        r_inv;
    logic [LATENCY_P-1:0]        w_in_inv;
`endif

    // A stage can take new data if it is empty or its occupant leaves this cycle.
    always_comb begin : open_chain
        logic v_chain;
        v_chain = yumi_i;
        w_open  = '0;
        for (int k = LATENCY_P - 1; k >= 0; k--) begin
            v_chain   = ~r_valid[k] | v_chain;
            w_open[k] = v_chain;
        end
    end

    assign ready_o  = w_open[0] & ~reset_i;
    assign w_accept = v_i & ready_o;

    always_comb begin
        w_in_valid     = '0;
        w_in_valid[0]  = w_accept;
        w_in_result[0] = w_result;
        w_in_rd[0]     = rd_i;
`ifdef FPU_FLOAT_AUX_PIPE_INVALID_EN
        w_in_inv       = '0;
        w_in_inv[0]    = w_inv;
`endif
        for (int k = 1; k < LATENCY_P; k++) begin
            w_in_valid[k]  = r_valid[k-1];
            w_in_result[k] = r_result[k-1];
            w_in_rd[k]     = r_rd[k-1];
`ifdef FPU_FLOAT_AUX_PIPE_INVALID_EN
            w_in_inv[k]    = r_inv[k-1];
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_valid <= '0;
`ifdef FPU_FLOAT_AUX_PIPE_INVALID_EN
            r_inv   <= '0;
`endif
            for (int k = 0; k < LATENCY_P; k++) begin
                r_result[k] <= '0;
                r_rd[k]     <= '0;
            end
        end else begin
            for (int k = 0; k < LATENCY_P; k++) begin
                if (w_open[k]) begin
                    r_valid[k] <= w_in_valid[k];
                    if (w_in_valid[k]) begin
                        r_result[k] <= w_in_result[k];
                        r_rd[k]     <= w_in_rd[k];
`ifdef FPU_FLOAT_AUX_PIPE_INVALID_EN
                        r_inv[k]    <= w_in_inv[k];
`endif
                    end
                end
            end
        end
    end

    assign v_o      = r_valid[LATENCY_P-1];
    assign result_o = r_result[LATENCY_P-1];
    assign rd_o     = r_rd[LATENCY_P-1];
    assign busy_o   = |r_valid;
`ifdef FPU_FLOAT_AUX_PIPE_INVALID_EN
    assign invalid_o = r_inv[LATENCY_P-1];
`endif

`ifndef SYNTHESIS
    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
                                         !(yumi_i && !v_o));
`endif

endmodule
`default_nettype wire
